// File: rtl/eth_types_pkg.sv
// Shared Ethernet transmit-path types and constants.
package eth_types_pkg;

    // Minimum inter-frame gap in byte times.
    localparam int unsigned ETH_IFG_BYTES = 12;
    // Maximum untagged frame length in bytes (without preamble).
    localparam int unsigned ETH_MAX_FRAME = 1518;
    // Reference clocks per byte on RMII at 100 Mb/s (2 bits per clock).
    localparam int unsigned RMII_CLK_PER_BYTE = 4;

    // Transmit arbiter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        IFG   = 2'd3
    } tx_arb_state_t;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder: searches upward from last_grant+1 with wrap.
module rr_picker
    import eth_types_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned GW = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      pick,
    output logic               any_req
);

    logic [2*NUM_SRC-1:0] req_dbl;
    logic [NUM_SRC-1:0]   req_rot;
    logic [GW:0]          rot_amt;

    // Rotate requests so bit 0 is the source just after last_grant, then take the lowest set bit.
    always_comb begin
        rot_amt = (GW+1)'(last_grant) + (GW+1)'(1);
        req_dbl = {req, req};
        req_rot = NUM_SRC'(req_dbl >> rot_amt);
        pick    = '0;
        any_req = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick    = GW'((int'(last_grant) + 1 + i) % int'(NUM_SRC));
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing the RMII transmit byte path between frame sources.
// Enforces the inter-frame gap, caps frame length and aborts frames whose source underruns.
module eth_tx_arbiter
    import eth_types_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 2,
    parameter int unsigned IFG_CYCLES      = ETH_IFG_BYTES * RMII_CLK_PER_BYTE,
    parameter int unsigned MAX_FRAME_BYTES = ETH_MAX_FRAME,
    parameter int unsigned STALL_CYCLES    = 8,
    localparam int unsigned GW = idx_width(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic                 tx_abort,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam int unsigned BCW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int unsigned SCW = $clog2(STALL_CYCLES + 1);
    localparam int unsigned ICW = idx_width(IFG_CYCLES);

    tx_arb_state_t state;
    tx_arb_state_t state_next;

    logic [GW-1:0]  last_grant;
    logic [BCW-1:0] byte_cnt;
    logic [SCW-1:0] stall_cnt;
    logic [ICW-1:0] ifg_cnt;

    logic [GW-1:0]  pick;
    logic           any_req;

    logic [7:0]     sel_data;
    logic           sel_valid;
    logic           sel_last;

    logic           xfer_fire;
    logic           drain_fire;
    logic           abort_evt;
    logic           frame_done;

    // Round-robin choice among current requesters, lowest priority to the last finisher.
    rr_picker #(
        .NUM_SRC    (NUM_SRC)
    ) u_picker (
        .req        (src_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_req    (any_req)
    );

    // Select the granted source's byte, valid and last.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                sel_data  = src_data[i*8 +: 8];
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
            end
        end
    end

    assign xfer_fire  = (state == XFER)  && sel_valid && tx_ready;
    assign drain_fire = (state == DRAIN) && sel_valid;

    // State register; reset drops any frame in flight without an abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the frame-end and abort events that drive the counters.
    always_comb begin
        state_next = state;
        abort_evt  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (xfer_fire && sel_last) begin
                    state_next = IFG;
                    frame_done = 1'b1;
                end else if (xfer_fire && (byte_cnt == BCW'(MAX_FRAME_BYTES - 1))) begin
                    state_next = DRAIN;
                    abort_evt  = 1'b1;
                end else if (!sel_valid && (stall_cnt == SCW'(STALL_CYCLES - 1))) begin
                    state_next = DRAIN;
                    abort_evt  = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_fire && sel_last) begin
                    state_next = IFG;
                    frame_done = 1'b1;
                end
            end
            IFG: begin
                if (ifg_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte-path outputs: pass-through in XFER, silent sink in DRAIN, quiet elsewhere.
    always_comb begin
        tx_byte   = '0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        src_ready = '0;
        busy      = (state != IDLE);
        case (state)
            XFER: begin
                tx_byte  = sel_data;
                tx_valid = sel_valid;
                tx_last  = sel_last;
                for (int i = 0; i < NUM_SRC; i++) begin
                    src_ready[i] = (grant_id == GW'(i)) && tx_ready;
                end
            end
            DRAIN: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    src_ready[i] = (grant_id == GW'(i));
                end
            end
            default: begin
            end
        endcase
    end

    // Grant register and fairness pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
        end else begin
            if ((state == IDLE) && any_req) begin
                grant_id <= pick;
            end
            if (frame_done || abort_evt) begin
                last_grant <= grant_id;
            end
        end
    end

    // One-cycle abort pulse toward the transmitter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_abort <= 1'b0;
        end else begin
            tx_abort <= abort_evt;
        end
    end

    // Accepted-byte count for the frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (state == IDLE) begin
            byte_cnt <= '0;
        end else if (xfer_fire) begin
            byte_cnt <= byte_cnt + BCW'(1);
        end
    end

    // Consecutive cycles the granted source has held valid low mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == XFER) begin
            stall_cnt <= sel_valid ? '0 : stall_cnt + SCW'(1);
        end else begin
            stall_cnt <= '0;
        end
    end

    // Inter-frame gap countdown, loaded at every frame end including aborted ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifg_cnt <= '0;
        end else if (frame_done) begin
            ifg_cnt <= ICW'(IFG_CYCLES - 1);
        end else if ((state == IFG) && (ifg_cnt != '0)) begin
            ifg_cnt <= ifg_cnt - ICW'(1);
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: source models push expected bytes, the tx monitor pops them.
module tb_eth_tx_arbiter;

    localparam int unsigned NSRC = 2;
    localparam int unsigned GW   = 1;
    localparam int          BIG  = 1 << 30;

    logic                clk = 1'b0;
    logic                reset;
    logic [NSRC*8-1:0]   src_data;
    logic [NSRC-1:0]     src_valid;
    logic [NSRC-1:0]     src_last;
    logic [NSRC-1:0]     src_ready;
    logic [7:0]          tx_byte;
    logic                tx_valid;
    logic                tx_last;
    logic                tx_ready;
    logic                tx_abort;
    logic [GW-1:0]       grant_id;
    logic                busy;

    always #10 clk = ~clk;

    eth_tx_arbiter #(
        .NUM_SRC   (NSRC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_ready (src_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .tx_abort  (tx_abort),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   starts_src[$];
    int   starts_gid[$];
    int   gaps[$];
    int   busy_runs[$];

    int n_run  = 0;
    int n_fail = 0;

    int cyc = 0;
    int last_xfer_cyc, last_end_cyc, abort_cnt, abort_gap, drained, last_cnt, tx_cnt, busy_cnt;
    bit gap_wait, busy_trk, first_byte, ready_slow;

    // Per-source frame generator state.
    int len[NSRC], pos[NSRC], frames_left[NSRC], frame_no[NSRC];
    int stall_at[NSRC], stall_len[NSRC], stall_rem[NSRC], drop_from[NSRC], delay[NSRC];
    bit hs[NSRC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int s, input int f, input int i);
        return 8'((i + s * 89 + f * 17) & 255);
    endfunction

    function automatic bit src_on(input int s);
        return (frames_left[s] > 0) && (delay[s] == 0) && (stall_rem[s] == 0);
    endfunction

    function automatic bit pending();
        for (int s = 0; s < NSRC; s++) begin
            if (frames_left[s] > 0) return 1'b1;
        end
        return busy || (exp_q.size() != 0);
    endfunction

    task automatic drive();
        for (int s = 0; s < NSRC; s++) begin
            src_valid[s]       = src_on(s);
            src_data[s*8 +: 8] = byte_of(s, frame_no[s], pos[s]);
            src_last[s]        = (pos[s] == len[s] - 1);
        end
        tx_ready = ready_slow ? (cyc % 4 == 0) : 1'b1;
    endtask

    task automatic setup_src(input int s, input int l, input int frames, input int st_at,
                             input int st_len, input int drop, input int dly);
        len[s]         = l;
        pos[s]         = 0;
        frames_left[s] = frames;
        frame_no[s]    = 0;
        stall_at[s]    = st_at;
        stall_len[s]   = st_len;
        stall_rem[s]   = 0;
        drop_from[s]   = drop;
        delay[s]       = dly;
    endtask

    task automatic new_test(input bit slow);
        ready_slow = slow;
        starts_src.delete();
        starts_gid.delete();
        gaps.delete();
        busy_runs.delete();
        abort_cnt  = 0;
        abort_gap  = -1;
        drained    = 0;
        last_cnt   = 0;
        tx_cnt     = 0;
        gap_wait   = 1'b0;
        busy_trk   = 1'b0;
        first_byte = 1'b1;
        for (int s = 0; s < NSRC; s++) begin
            hs[s] = 1'b0;
            setup_src(s, 1, 0, -1, 0, BIG, 0);
        end
    endtask

    // Sampled mid-cycle: source handshakes feed the scoreboard, tx handshakes drain it.
    task automatic monitor();
        exp_t e;
        cyc++;
        if (gap_wait && tx_valid) begin
            gaps.push_back(cyc - last_end_cyc - 1);
            gap_wait = 1'b0;
        end
        if (busy_trk) begin
            if (busy) begin
                busy_cnt++;
            end else begin
                busy_runs.push_back(busy_cnt);
                busy_trk = 1'b0;
            end
        end
        for (int s = 0; s < NSRC; s++) begin
            hs[s] = src_valid[s] && src_ready[s];
            if (hs[s]) begin
                if (pos[s] < drop_from[s]) begin
                    e.src  = s;
                    e.data = byte_of(s, frame_no[s], pos[s]);
                    e.last = (pos[s] == len[s] - 1);
                    exp_q.push_back(e);
                end else begin
                    drained++;
                end
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("tx_without_expected", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                tx_cnt++;
                check_eq("tx_byte", 32'(tx_byte), 32'(e.data));
                check_eq("tx_last", 32'(tx_last), 32'(e.last));
                if (first_byte) begin
                    starts_src.push_back(e.src);
                    starts_gid.push_back(int'(grant_id));
                    first_byte = 1'b0;
                end
                last_xfer_cyc = cyc;
                if (tx_last) begin
                    last_cnt++;
                    first_byte   = 1'b1;
                    last_end_cyc = cyc;
                    gap_wait     = 1'b1;
                    busy_trk     = 1'b1;
                    busy_cnt     = 0;
                end
            end
        end
        if (tx_abort) begin
            abort_cnt++;
            abort_gap  = cyc - last_xfer_cyc;
            first_byte = 1'b1;
        end
    endtask

    task automatic update();
        for (int s = 0; s < NSRC; s++) begin
            if (hs[s]) begin
                if (pos[s] == len[s] - 1) begin
                    frames_left[s]--;
                    frame_no[s]++;
                    pos[s] = 0;
                end else begin
                    pos[s]++;
                    if (pos[s] == stall_at[s]) stall_rem[s] = stall_len[s];
                end
            end else if (stall_rem[s] > 0) begin
                stall_rem[s]--;
            end else if (delay[s] > 0) begin
                delay[s]--;
            end
        end
        drive();
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check_eq("finish_within_budget", 32'(pending()), 0);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 0);
    endtask

    // Expected grant order: one hex nibble per frame, first frame in the lowest nibble.
    task automatic check_starts(input string tag, input int nframes, input int order);
        int want;
        check_eq({tag, "_frames"}, 32'(starts_src.size()), 32'(nframes));
        for (int i = 0; i < nframes && i < starts_src.size(); i++) begin
            want = (order >> (4 * i)) & 15;
            check_eq($sformatf("%s_src%0d", tag, i), 32'(starts_src[i]), 32'(want));
            check_eq($sformatf("%s_gid%0d", tag, i), 32'(starts_gid[i]), 32'(want));
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_src_ready"}, 32'(src_ready), 0);
        check_eq({tag, "_tx_valid"},  32'(tx_valid), 0);
        check_eq({tag, "_tx_last"},   32'(tx_last), 0);
        check_eq({tag, "_tx_abort"},  32'(tx_abort), 0);
        check_eq({tag, "_tx_byte"},   32'(tx_byte), 0);
        check_eq({tag, "_grant_id"},  32'(grant_id), 0);
        check_eq({tag, "_busy"},      32'(busy), 0);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: time %0t reached limit without finishing", $time);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        new_test(1'b0);
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("por");
        reset = 1'b0;

        // Single 64-byte frame from source 0.
        new_test(1'b0);
        setup_src(0, 64, 1, -1, 0, BIG, 0);
        drive();
        run(400);
        check_starts("single", 1, 'h0);
        check_eq("single_tx_cnt", 32'(tx_cnt), 64);
        check_eq("single_last_cnt", 32'(last_cnt), 1);
        check_eq("single_abort_cnt", 32'(abort_cnt), 0);
        check_eq("single_busy_runs", 32'(busy_runs.size()), 1);
        if (busy_runs.size() > 0) check_eq("single_busy_after_last", 32'(busy_runs[0]), 48);

        // Source 1, 100 bytes with tx_ready high one cycle in four.
        new_test(1'b1);
        setup_src(1, 100, 1, -1, 0, BIG, 0);
        drive();
        run(1200);
        check_starts("slow", 1, 'h1);
        check_eq("slow_tx_cnt", 32'(tx_cnt), 100);
        check_eq("slow_last_cnt", 32'(last_cnt), 1);
        check_eq("slow_abort_cnt", 32'(abort_cnt), 0);

        // Both sources request continuously, three frames each.
        new_test(1'b0);
        setup_src(0, 12, 3, -1, 0, BIG, 0);
        setup_src(1, 12, 3, -1, 0, BIG, 0);
        drive();
        run(1000);
        check_starts("rr", 6, 'h101010);
        check_eq("rr_abort_cnt", 32'(abort_cnt), 0);
        check_eq("rr_gap_count", 32'(gaps.size()), 5);
        foreach (gaps[i]) check_eq($sformatf("rr_gap%0d", i), 32'(gaps[i]), 49);
        check_eq("rr_busy_runs", 32'(busy_runs.size()), 6);
        foreach (busy_runs[i]) check_eq($sformatf("rr_busy%0d", i), 32'(busy_runs[i]), 48);

        // Source 1 stalls 8 cycles after byte 20; source 0 waits and goes next.
        new_test(1'b0);
        setup_src(1, 40, 1, 20, 8, 20, 0);
        setup_src(0, 16, 1, -1, 0, BIG, 5);
        drive();
        run(600);
        check_starts("stall", 2, 'h01);
        check_eq("stall_abort_cnt", 32'(abort_cnt), 1);
        check_eq("stall_abort_delay", 32'(abort_gap), 9);
        check_eq("stall_drained", 32'(drained), 20);
        check_eq("stall_tx_cnt", 32'(tx_cnt), 36);
        check_eq("stall_last_cnt", 32'(last_cnt), 1);

        // 1600-byte frame is cut at the 1518th byte and the rest drained.
        new_test(1'b0);
        setup_src(1, 1600, 1, -1, 0, 1518, 0);
        drive();
        run(2500);
        check_starts("long", 1, 'h1);
        check_eq("long_abort_cnt", 32'(abort_cnt), 1);
        check_eq("long_abort_delay", 32'(abort_gap), 1);
        check_eq("long_tx_cnt", 32'(tx_cnt), 1518);
        check_eq("long_drained", 32'(drained), 82);
        check_eq("long_last_cnt", 32'(last_cnt), 0);

        // Reset asserted mid-frame, then both sources request after release.
        new_test(1'b0);
        setup_src(1, 30, 1, -1, 0, BIG, 0);
        drive();
        n = 0;
        while (pos[1] < 10 && n < 200) begin
            step();
            n++;
        end
        check_eq("rst_reached_byte10", 32'(pos[1]), 10);
        check_eq("rst_grant_before", 32'(grant_id), 1);
        #4;
        reset = 1'b1;
        #1;
        check_quiet("rst_async");
        exp_q.delete();
        new_test(1'b0);
        setup_src(0, 20, 1, -1, 0, BIG, 0);
        setup_src(1, 20, 1, -1, 0, BIG, 0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run(600);
        check_starts("rst_after", 2, 'h10);
        check_eq("rst_abort_cnt", 32'(abort_cnt), 0);
        check_eq("rst_last_cnt", 32'(last_cnt), 2);
        check_eq("rst_tx_cnt", 32'(tx_cnt), 40);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
